// File: rtl/mul4_tournament_evaluator.sv
// Drives an evolved mul4 candidate with LFSR operand pairs and scores its outputs bitwise against A*B.
// Done pulses NUM_VECTORS*(SETTLE_CYCLES+2)+1 cycles after start; no backpressure, abort cancels.
module mul4_tournament_evaluator #(
    parameter int NUM_VECTORS   = 256,
    parameter int SETTLE_CYCLES = 1,
    parameter int SCORE_W       = 24
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               abort,
    input  logic [31:0]        seed,
    output logic [15:0]        cand_a1,
    output logic [15:0]        cand_a0,
    output logic [15:0]        cand_b1,
    output logic [15:0]        cand_b0,
    input  logic [15:0]        cand_y3,
    input  logic [15:0]        cand_y2,
    input  logic [15:0]        cand_y1,
    input  logic [15:0]        cand_y0,
    output logic               busy,
    output logic               done,
    output logic [SCORE_W-1:0] score,
    output logic [15:0]        perfect_cnt
);

    typedef enum logic [2:0] {ST_IDLE, ST_DRIVE, ST_WAIT, ST_COMPARE, ST_FIN} state_t;

    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        return s[0] ? ((s >> 1) ^ 32'h8020_0003) : (s >> 1);
    endfunction

    function automatic logic [6:0] popcount64(input logic [63:0] v);
        logic [6:0] cnt;
        cnt = 7'd0;
        for (int i = 0; i < 64; i++) begin
            cnt = cnt + 7'(v[i]);
        end
        return cnt;
    endfunction

    state_t               r_state, w_state_nxt;
    logic [31:0]          r_lfsr;
    logic [31:0]          r_op_a, r_op_b;
    logic [63:0]          r_gold;
    logic [15:0]          r_vec_cnt;
    logic [3:0]           r_wait_cnt;
    logic                 r_busy, r_done;
    logic [SCORE_W-1:0]   r_score;
    logic [15:0]          r_perfect;

    logic [31:0]          w_lfsr_b, w_lfsr_nxt;
    logic [63:0]          w_cand_y;
    logic [6:0]           w_match;
    logic [15:0]          w_vec_inc;
    logic                 w_last, w_abort;

    assign w_lfsr_b   = lfsr_step(r_lfsr);
    assign w_lfsr_nxt = lfsr_step(w_lfsr_b);
    assign w_cand_y   = {cand_y3, cand_y2, cand_y1, cand_y0};
    assign w_match    = popcount64(~(w_cand_y ^ r_gold));
    assign w_vec_inc  = r_vec_cnt + 16'd1;
    assign w_last     = (w_vec_inc == 16'(NUM_VECTORS));
    assign w_abort    = (r_state != ST_IDLE) && abort;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (start) w_state_nxt = ST_DRIVE;
            ST_DRIVE:   w_state_nxt = (SETTLE_CYCLES > 0) ? ST_WAIT : ST_COMPARE;
            ST_WAIT:    if (r_wait_cnt == 4'(SETTLE_CYCLES - 1)) w_state_nxt = ST_COMPARE;
            ST_COMPARE: w_state_nxt = w_last ? ST_FIN : ST_DRIVE;
            ST_FIN:     w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
        // Abort wins over every in-flight transition, including the last COMPARE.
        if (w_abort) w_state_nxt = ST_IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lfsr     <= 32'd1;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_gold     <= '0;
            r_vec_cnt  <= '0;
            r_wait_cnt <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_score    <= '0;
            r_perfect  <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_abort) begin
                r_busy <= 1'b0;
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (start) begin
                            r_lfsr    <= (seed == 32'd0) ? 32'd1 : seed;
                            r_score   <= '0;
                            r_perfect <= '0;
                            r_vec_cnt <= '0;
                            r_busy    <= 1'b1;
                        end
                    end
                    ST_DRIVE: begin
                        r_op_a     <= r_lfsr;
                        r_op_b     <= w_lfsr_b;
                        r_gold     <= {32'd0, r_lfsr} * {32'd0, w_lfsr_b};
                        r_lfsr     <= w_lfsr_nxt;
                        r_wait_cnt <= '0;
                    end
                    ST_WAIT: r_wait_cnt <= r_wait_cnt + 4'd1;
                    ST_COMPARE: begin
                        r_score   <= r_score + SCORE_W'(w_match);
                        if ((w_match == 7'd64) && (r_perfect != 16'hFFFF)) begin
                            r_perfect <= r_perfect + 16'd1;
                        end
                        r_vec_cnt <= w_vec_inc;
                    end
                    ST_FIN: begin
                        r_done <= 1'b1;
                        r_busy <= 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign cand_a1     = r_op_a[31:16];
    assign cand_a0     = r_op_a[15:0];
    assign cand_b1     = r_op_b[31:16];
    assign cand_b0     = r_op_b[15:0];
    assign busy        = r_busy;
    assign done        = r_done;
    assign score       = r_score;
    assign perfect_cnt = r_perfect;

endmodule
